sr_wb_shifter: RTL and testbench

- Wishbone-slave serial shift engine in the Caravel user project area; it is the DUT logic the sr_wb firmware drives.
- Firmware writes a word, length, divider and direction over Wishbone, then starts a transfer.
- The block shifts the word out on mprj_io pins (clock/data/latch) while sampling a serial input, and exposes received data plus busy/done status to firmware.
- Firmware reports pass/fail on mprj_io[1:0].

---
 rtl/sr_wb_shifter.sv | 185 ++++++++++++++++++
 tb/tb_sr_wb_shifter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_wb_shifter.sv
// rtl/sr_wb_shifter.sv - Wishbone-slave serial shift engine (clock/data/latch out, serial sample in)
//
// Purpose: firmware loads TXDATA, LEN, DIV and direction over Wishbone, then
// writes START. The word is shifted out on sr_dout_o with sr_clk_o, sr_din_i is
// sampled on each rising serial clock, and sr_latch_o pulses after the last bit.
//
// Ports:
//   wb_clk_i, wb_rst_i          system clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone request qualifiers
//   wbs_sel_i[3:0]              byte lane selects for writes
//   wbs_adr_i[31:0]             byte address, window BASE_ADDR..+0x1F
//   wbs_dat_i[31:0]             write data
//   wbs_ack_o, wbs_dat_o[31:0]  single-cycle ack with read data
//   sr_din_i                    serial data in
//   sr_clk_o, sr_dout_o         serial clock and data out
//   sr_latch_o                  latch strobe after the last bit
//   io_oeb[2:0]                 pad output-enable-bar, always driven (0)
module sr_wb_shifter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DIV_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        sr_din_i,
  output logic        sr_clk_o,
  output logic        sr_dout_o,
  output logic        sr_latch_o,
  output logic [2:0]  io_oeb
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  state_t state, state_next;

  logic [4:0]       len_q;
  logic             msb_q;
  logic [DIV_W-1:0] div_q;
  logic [31:0]      tx_q;
  logic [31:0]      rx_q;
  logic             done_q;
  logic [31:0]      tx_sh;
  logic [31:0]      rx_sh;
  logic [DIV_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      rd;

  // Byte offset bits are don't-care for a word-addressed register file.
  logic unused_adr;
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  assign io_oeb = 3'b000;

  logic       req, acc, wr, busy, start_go, phase_end;
  logic [2:0] reg_sel;
  logic [4:0] idx;

  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  // Accept only when ack is low so each request yields exactly one ack cycle.
  assign acc     = req & ~wbs_ack_o;
  assign wr      = acc & wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];
  assign busy    = (state != IDLE);
  assign start_go = wr && (reg_sel == 3'd0) && wbs_sel_i[3] && wbs_dat_i[31] && !busy;
  assign phase_end = (cnt == div_q);
  // Bit position of the current serial slot; shared by TX and RX so the first
  // received bit lands where the first transmitted bit came from.
  assign idx = msb_q ? (len_q - bit_cnt) : bit_cnt;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] ctrl_new, div_new, tx_new;
  assign ctrl_new = merge({23'b0, msb_q, 3'b0, len_q}, wbs_dat_i, wbs_sel_i);
  assign div_new  = merge({{(32-DIV_W){1'b0}}, div_q}, wbs_dat_i, wbs_sel_i);
  assign tx_new   = merge(tx_q, wbs_dat_i, wbs_sel_i);

  always_comb begin
    rd = 32'h0;
    case (reg_sel)
      3'd0:    rd = {23'b0, msb_q, 3'b0, len_q};
      3'd1:    rd = {{(32-DIV_W){1'b0}}, div_q};
      3'd2:    rd = tx_q;
      3'd3:    rd = rx_q;
      3'd4:    rd = {30'b0, done_q, busy};
      default: rd = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_go)  state_next = LOW;
      LOW:   if (phase_end) state_next = HIGH;
      HIGH:  if (phase_end) state_next = (bit_cnt == len_q) ? LATCH : LOW;
      LATCH: if (phase_end) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sr_clk_o   = (state == HIGH);
    sr_latch_o = (state == LATCH);
    sr_dout_o  = 1'b0;
    if (state == LOW || state == HIGH) sr_dout_o = tx_sh[idx];
  end

  // Wishbone registers and shift datapath
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      len_q     <= 5'd0;
      msb_q     <= 1'b0;
      div_q     <= '0;
      tx_q      <= 32'h0;
      rx_q      <= 32'h0;
      done_q    <= 1'b0;
      tx_sh     <= 32'h0;
      rx_sh     <= 32'h0;
      cnt       <= '0;
      bit_cnt   <= 5'd0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= acc ? rd : 32'h0;

      if (wr && !busy) begin
        case (reg_sel)
          3'd0: begin
            len_q <= ctrl_new[4:0];
            msb_q <= ctrl_new[8];
          end
          3'd1:    div_q <= div_new[DIV_W-1:0];
          3'd2:    tx_q  <= tx_new;
          default: ;
        endcase
      end

      if (wr && reg_sel == 3'd4 && wbs_sel_i[0] && wbs_dat_i[1]) done_q <= 1'b0;

      if (start_go) begin
        tx_sh   <= tx_q;
        rx_sh   <= 32'h0;
        rx_q    <= 32'h0;
        bit_cnt <= 5'd0;
      end

      if (state_next != state) cnt <= '0;
      else if (busy)           cnt <= cnt + DIV_W'(1);

      if (state == HIGH && cnt == '0) rx_sh[idx] <= sr_din_i;

      if (state == HIGH && phase_end && bit_cnt != len_q) bit_cnt <= bit_cnt + 5'd1;

      // Placed after the W1C so a simultaneous set wins.
      if (state == LATCH && phase_end) begin
        rx_q   <= rx_sh;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_wb_shifter.sv
// tb/tb_sr_wb_shifter.sv - directed self-checking bench for sr_wb_shifter
module tb_sr_wb_shifter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        sr_din, sr_clk, sr_dout, sr_latch;
  logic [2:0]  io_oeb;
  logic        loop_mode, din_level;

  int errors = 0;
  int checks = 0;

  logic clk_s   [0:79];
  logic dout_s  [0:79];
  logic latch_s [0:79];
  logic start_ack;

  assign sr_din = loop_mode ? sr_dout : din_level;

  always #5 clk = ~clk;

  sr_wb_shifter #(.BASE_ADDR(BASE), .DIV_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .sr_din_i(sr_din), .sr_clk_o(sr_clk), .sr_dout_o(sr_dout),
    .sr_latch_o(sr_latch), .io_oeb(io_oeb)
  );

  // Bus driver: returns read data and number of cycles ack was seen high.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output int acks);
    logic got;
    got = 1'b0; acks = 0; r = 32'h0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; r = dat_o; acks++; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (got) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
  endtask

  task automatic wb_wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] r; int n;
    wb_xfer(1'b1, BASE + off, d, 4'hF, r, n);
  endtask

  task automatic wb_rd(input logic [31:0] off, output logic [31:0] r);
    int n;
    wb_xfer(1'b0, BASE + off, 32'h0, 4'hF, r, n);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Issues a START write to CTRL and records serial outputs each cycle,
  // index 0 being the first cycle after the accepting edge.
  task automatic start_and_capture(input logic [31:0] ctrl_val, input int n);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_i = ctrl_val; sel = 4'hF;
    @(posedge clk); #1;
    start_ack = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) begin
      clk_s[i] = sr_clk; dout_s[i] = sr_dout; latch_s[i] = sr_latch;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if ({ack, dat_o, sr_clk, sr_dout, sr_latch, io_oeb} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b dat=%h clk=%b dout=%b latch=%b oeb=%b, want all 0",
               ack, dat_o, sr_clk, sr_dout, sr_latch, io_oeb);
    end
    rst = 1'b0;
    wait_cycles(1);
    for (int k = 0; k < 5; k++) begin
      wb_rd(32'(k) * 4, r);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want 00000000", k, r);
      end
    end
  endtask

  task automatic test_register_rw();
    logic [31:0] r; int n;
    wb_xfer(1'b1, BASE + 32'h04, 32'h0000_0003, 4'hF, r, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL ack_div_write: got %0d ack cycles want 1", n); end
    wb_xfer(1'b1, BASE + 32'h08, 32'hA5A5_1234, 4'b0011, r, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL ack_tx_write: got %0d ack cycles want 1", n); end
    wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, r, n);
    checks++;
    if (r !== 32'h0000_1234 || n !== 1) begin
      errors++; $display("FAIL tx_bytemask: got %h acks=%0d want 00001234 acks=1", r, n);
    end
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, r, n);
    checks++;
    if (r !== 32'h0000_0003) begin errors++; $display("FAIL div_readback: got %h want 00000003", r); end
    wb_xfer(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, r, n);
    wb_xfer(1'b0, BASE + 32'h18, 32'h0, 4'hF, r, n);
    checks++;
    if (r !== 32'h0 || n !== 1) begin
      errors++; $display("FAIL reserved_read: got %h acks=%0d want 00000000 acks=1", r, n);
    end
  endtask

  task automatic test_msb_loopback();
    logic [31:0] r;
    logic [7:0]  exp_bits;
    int bad_d, bad_c;
    exp_bits = 8'hA5;
    loop_mode = 1'b1;
    wb_wr(32'h04, 32'h1);
    wb_wr(32'h08, 32'hA5);
    start_and_capture(32'h8000_0107, 40);
    checks++;
    if (start_ack !== 1'b1) begin errors++; $display("FAIL msb_start_ack: got %b want 1", start_ack); end
    bad_d = 0; bad_c = 0;
    for (int k = 0; k < 8; k++) begin
      if (dout_s[4*k] !== exp_bits[7-k] || dout_s[4*k+3] !== exp_bits[7-k]) bad_d++;
      if (clk_s[4*k] !== 1'b0 || clk_s[4*k+1] !== 1'b0 ||
          clk_s[4*k+2] !== 1'b1 || clk_s[4*k+3] !== 1'b1) bad_c++;
    end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL msb_dout_seq: got %0d wrong bits want 0", bad_d); end
    checks++;
    if (bad_c != 0) begin errors++; $display("FAIL msb_clk_shape: got %0d wrong periods want 0", bad_c); end
    checks++;
    if ({latch_s[31], latch_s[32], latch_s[33], latch_s[34]} !== 4'b0110 ||
        clk_s[34] !== 1'b0 || dout_s[34] !== 1'b0) begin
      errors++;
      $display("FAIL msb_latch_timing: got latch[31..34]=%b%b%b%b clk34=%b want 0110 clk34=0",
               latch_s[31], latch_s[32], latch_s[33], latch_s[34], clk_s[34]);
    end
    wb_rd(32'h0C, r);
    checks++;
    if (r !== 32'h0000_00A5) begin errors++; $display("FAIL msb_rxdata: got %h want 000000a5", r); end
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL msb_status: got %h want 00000002", r); end
    loop_mode = 1'b0;
  endtask

  task automatic test_lsb_32bit();
    logic [31:0] r, tx;
    int bad;
    tx = 32'h8000_0001;
    din_level = 1'b1;
    wb_wr(32'h10, 32'h2);
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL done_w1c: got %h want 00000000", r); end
    wb_wr(32'h04, 32'h0);
    wb_wr(32'h08, tx);
    start_and_capture(32'h8000_001F, 70);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (dout_s[2*k] !== tx[k] || clk_s[2*k] !== 1'b0 || clk_s[2*k+1] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lsb_serial_seq: got %0d wrong bits want 0", bad); end
    checks++;
    if ({latch_s[63], latch_s[64], latch_s[65]} !== 3'b010) begin
      errors++;
      $display("FAIL lsb_latch_timing: got %b%b%b want 010", latch_s[63], latch_s[64], latch_s[65]);
    end
    wb_rd(32'h0C, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lsb_rxdata: got %h want ffffffff", r); end
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL lsb_done: got %h want 00000002", r); end
    din_level = 1'b0;
  endtask

  task automatic test_busy_lockout();
    logic [31:0] r;
    loop_mode = 1'b1;
    wb_wr(32'h10, 32'h2);
    wb_wr(32'h04, 32'h1);
    wb_wr(32'h08, 32'h3C);
    wb_wr(32'h00, 32'h8000_0107);
    wb_wr(32'h08, 32'h0000_DEAD);
    wb_wr(32'h00, 32'h8000_0003);
    wb_wr(32'h04, 32'h5);
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL lockout_busy: got %h want 00000001", r); end
    wait_cycles(40);
    wb_rd(32'h0C, r);
    checks++;
    if (r !== 32'h3C) begin errors++; $display("FAIL lockout_rxdata: got %h want 0000003c", r); end
    wb_rd(32'h08, r);
    checks++;
    if (r !== 32'h3C) begin errors++; $display("FAIL lockout_txdata: got %h want 0000003c", r); end
    wb_rd(32'h00, r);
    checks++;
    if (r !== 32'h107) begin errors++; $display("FAIL lockout_ctrl: got %h want 00000107", r); end
    wb_rd(32'h04, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL lockout_div: got %h want 00000001", r); end
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL lockout_status_done: got %h want 00000002", r); end
    wb_wr(32'h10, 32'h2);
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL lockout_w1c: got %h want 00000000", r); end
    loop_mode = 1'b0;
  endtask

  task automatic test_out_of_window();
    logic [31:0] r; int n;
    wb_xfer(1'b1, BASE + 32'h28, 32'hFFFF_FFFF, 4'hF, r, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL oow_write_ack: got %0d ack cycles want 0", n); end
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, r, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL oow_read_ack: got %0d ack cycles want 0", n); end
    wb_rd(32'h08, r);
    checks++;
    if (r !== 32'h3C) begin errors++; $display("FAIL oow_no_change: got %h want 0000003c", r); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] r;
    int bad;
    wb_wr(32'h04, 32'h3);
    wb_wr(32'h08, 32'hFFFF_FFFF);
    wb_wr(32'h00, 32'h8000_011F);
    wait_cycles(20);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({ack, dat_o, sr_clk, sr_dout, sr_latch} !== 35'h0) bad++;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sr_clk !== 1'b0 || sr_latch !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_outputs: got %0d nonzero cycles want 0", bad); end
    wb_rd(32'h10, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want 00000000", r); end
    wb_rd(32'h0C, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midreset_rxdata: got %h want 00000000", r); end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_i = 32'h0; loop_mode = 1'b0; din_level = 1'b0;
    #1;
    test_reset();
    test_register_rw();
    test_msb_loopback();
    test_lsb_32bit();
    test_busy_lockout();
    test_out_of_window();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
